bcd_serial_adder: RTL and testbench
===================================

// Module: bcd_serial_adder
// PURPOSE
//  Digit-serial adder for multi-digit BCD operands. Operands are presented least
//  significant digit first, one digit pair per accepted beat, with a valid/ready
//  handshake on each side. Sits directly downstream of the per-digit BCD
//  validators and consumes their invalid flags (a_inv/b_inv, 1 = digit > 9).
//  Emits one decimal-corrected sum digit per beat, plus the final carry and error
//  flags.
// PARAMETERS
//  NDIG  4  maximum digits per operation; sets digit-counter width clog2(NDIG+1)
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a_digit/b_digit/in_first/in_last/a_inv/b_inv are valid
//  in_ready   out  1      adder accepts the beat this cycle
//  in_first   in   1      beat is the LSD; carry is cleared before adding
//  in_last    in   1      beat is the MSD; closes the operation
//  a_digit    in   [0:3]  operand A digit, bit 0 = MSB (weight 8)
//  b_digit    in   [0:3]  operand B digit, bit 0 = MSB
//  a_inv      in   1      validator flag for a_digit (1 = invalid)
//  b_inv      in   1      validator flag for b_digit (1 = invalid)
//  out_valid  out  1      sum_digit and its flags are valid
//  out_ready  in   1      downstream consumes the output beat
//  sum_digit  out  [0:3]  BCD sum digit, bit 0 = MSB
//  out_last   out  1      this output beat is the MSD of the operation
//  carry_out  out  1      final decimal carry; meaningful only when out_last=1
//  digit_err  out  1      this beat had an invalid input digit
//  op_err     out  1      on the out_last beat: OR of all errors in the operation
// BEHAVIOUR
//  - Handshake: a beat transfers when in_valid & in_ready.
//    in_ready = ~out_valid | out_ready (one-entry output register).
//    Output pops when out_valid & out_ready.
//  - Latency: a beat accepted at edge N drives out_valid high after edge N.
//    The output is held stable until popped. Full throughput is 1 beat/clk.
//  - FSM IDLE: in_ready follows the handshake rule.
//    * An accepted beat with in_first=0 is discarded and produces no output.
//    * An accepted beat with in_first=1 starts the operation: carry=0, cnt=1,
//      then moves to RUN. If in_last is also 1, it stays in IDLE.
//  - FSM RUN: each accepted beat does cnt++.
//    * A beat with in_last=1, or cnt reaching NDIG, returns the FSM to IDLE.
//    * A beat in RUN with in_first=1 restarts the operation: carry=0, cnt=1.
//      The error accumulator is cleared. No out_last is emitted for the
//      abandoned operation.
//  - Arithmetic:
//    * s = a + b + carry, 5-bit (0..19).
//    * If s > 9: sum_digit = (s + 6)[3:0] and carry = 1.
//    * Otherwise: sum_digit = s[3:0] and carry = 0.
//  - Invalid beat (a_inv | b_inv): sum_digit = 4'b1111, digit_err = 1, carry
//    forced to 0, and the error accumulator is set.
//  - NDIG overflow: the NDIGth beat without in_last is emitted with out_last=1
//    and op_err=1. Later beats are discarded in IDLE until the next in_first.
//  - Flags on out_last beats: carry_out = the carry after that digit;
//    op_err = accumulated error. On non-last beats, carry_out and op_err are 0.
//  - Reset: out_valid=0, sum_digit=0, out_last=0, carry_out=0, digit_err=0,
//    op_err=0, in_ready=1, FSM=IDLE, cnt=0, carry=0. Reset mid-operation
//    discards the partial result and any pending output beat.
// CONFIGURATION
//  BCD_SELFCHECK_EN defined: invalid = a_inv | b_inv | (a_digit > 9) | (b_digit > 9).
//    Internal range checks back up the external validators.
//  BCD_SELFCHECK_EN undefined: invalid = a_inv | b_inv only. No internal comparators.
// TESTING
//  T1 457+368, beats (7,8)f,(5,6),(4,3),(0,0)l -> sum 5,2,8,0; carry_out=0; op_err=0.
//  T2 9999+0001, out_ready=1 -> sum 0,0,0,0 on 4 consecutive clks; carry_out=1.
//  T3 beat 2 a_digit=4'hC with a_inv=1 -> that beat sum_digit=F, digit_err=1;
//     the last beat has op_err=1.
//  T4 out_ready=0 for 3 clks mid-operation -> in_ready=0, output held stable,
//     no beats lost; result matches T1.
//  T5 NDIG=4, 5 beats with in_last=0 -> 4th output out_last=1, op_err=1;
//     5th beat discarded with no output.
//  T6 reset asserted after beat 2 -> all outputs 0, out_valid=0; a fresh T1
//     then completes correctly.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first, valid/ready on both sides with a one-entry output register.
// Optional macro BCD_SELFCHECK_EN adds internal digit range checks on top of the validator flags.
module bcd_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_first,
    input  logic       in_last,
    input  logic [0:3] a_digit,
    input  logic [0:3] b_digit,
    input  logic       a_inv,
    input  logic       b_inv,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [0:3] sum_digit,
    output logic       out_last,
    output logic       carry_out,
    output logic       digit_err,
    output logic       op_err
);

    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       last;
        logic       cout;
        logic       derr;
        logic       oerr;
    } beat_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;
    beat_t         out_q, out_d;
    logic          ov_q, ov_d;

    logic          accept;
    logic          take;
    logic          invalid;
    logic          carry_in;
    logic          acc_in;
    logic [CW-1:0] cnt_beat;
    logic [4:0]    s;
    logic [4:0]    s_adj;
    logic [3:0]    digit;
    logic          c_next;
    logic          ovf;
    logic          fin;
    logic          err_all;

    assign in_ready = ~ov_q | out_ready;
    assign accept   = in_valid & in_ready;
    // Beats arriving in IDLE without in_first belong to no operation and are dropped.
    assign take     = accept & (in_first | (state_q == RUN));

`ifdef BCD_SELFCHECK_EN
    assign invalid = a_inv | b_inv | (a_digit > 4'd9) | (b_digit > 4'd9);
`else
    assign invalid = a_inv | b_inv;
`endif

    assign carry_in = in_first ? 1'b0 : carry_q;
    assign acc_in   = in_first ? 1'b0 : err_q;
    assign cnt_beat = in_first ? CW'(1) : cnt_q + CW'(1);

    assign s     = {1'b0, a_digit} + {1'b0, b_digit} + {4'b0, carry_in};
    assign s_adj = s + 5'd6;

    always_comb begin
        digit  = s[3:0];
        c_next = 1'b0;
        if (invalid) begin
            digit  = 4'hF;
            c_next = 1'b0;
        end else if (s > 5'd9) begin
            digit  = s_adj[3:0];
            c_next = 1'b1;
        end
    end

    // Hitting NDIG without in_last force-closes the operation as an error.
    assign ovf     = ~in_last & (cnt_beat == CW'(NDIG));
    assign fin     = in_last | ovf;
    assign err_all = acc_in | invalid | ovf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = err_q;
        out_d   = out_q;
        ov_d    = ov_q;
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (take) begin
            state_d    = fin ? IDLE : RUN;
            cnt_d      = fin ? '0 : cnt_beat;
            carry_d    = c_next;
            err_d      = err_all;
            out_d.sum  = digit;
            out_d.last = fin;
            out_d.cout = fin & c_next;
            out_d.derr = invalid;
            out_d.oerr = fin & err_all;
            ov_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign sum_digit = out_q.sum;
    assign out_last  = out_q.last;
    assign carry_out = out_q.cout;
    assign digit_err = out_q.derr;
    assign op_err    = out_q.oerr;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: directed cases plus random beats against a decimal reference model.
module tb_bcd_serial_adder;
    localparam int NDIG = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic       in_valid = 1'b0, in_ready, in_first = 1'b0, in_last = 1'b0;
    logic [0:3] a_digit = 4'd0, b_digit = 4'd0, sum_digit;
    logic       a_inv = 1'b0, b_inv = 1'b0;
    logic       out_valid, out_ready, out_last, carry_out, digit_err, op_err;
    logic       rdy_man = 1'b1, rdy_rnd = 1'b1;
    bit         rdy_rand = 1'b0;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] expq[$], obsq[$];
    int         obs_t[$];

    bit m_active = 1'b0, m_err = 1'b0;
    int m_cnt = 0, m_carry = 0;

    assign out_ready = rdy_rand ? rdy_rnd : rdy_man;

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .a_digit(a_digit), .b_digit(b_digit),
        .a_inv(a_inv), .b_inv(b_inv), .out_valid(out_valid), .out_ready(out_ready),
        .sum_digit(sum_digit), .out_last(out_last), .carry_out(carry_out),
        .digit_err(digit_err), .op_err(op_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #2;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [7:0] cur();
        return {sum_digit, out_last, carry_out, digit_err, op_err};
    endfunction

    // Monitor: record popped beats and check stalled outputs stay put.
    logic [7:0] held;
    bit         stall = 1'b0;
    always @(negedge clk) begin
        if (!reset && out_valid && stall) begin
            checks++;
            assert (cur() === held) else begin
                errors++; $error("FAIL hold obs=%h exp=%h", cur(), held);
            end
        end
        if (!reset && out_valid && out_ready) begin
            obsq.push_back(cur());
            obs_t.push_back(cyc);
        end
        stall = !reset && out_valid && !out_ready;
        held  = cur();
    end

    // Reference: plain decimal digit addition, one operation at a time.
    function automatic void model(int a, int b, bit ai, bit bi, bit f, bit l);
        bit inv, ovf, fin;
        int d, c, s;
        logic [3:0] d4;
        if (!m_active && !f) return;
        if (f) begin m_carry = 0; m_cnt = 0; m_err = 0; end
        m_cnt++;
        inv = ai | bi;
`ifdef BCD_SELFCHECK_EN
        inv = inv | (a > 9) | (b > 9);
`endif
        if (inv) begin d = 15; c = 0; end
        else begin s = a + b + m_carry; d = s % 10; c = s / 10; end
        ovf = !l && (m_cnt == NDIG);
        fin = l | ovf;
        m_err = m_err | inv | ovf;
        d4 = 4'(d);
        expq.push_back({d4, fin, fin & (c != 0), inv, fin & m_err});
        m_carry  = c;
        m_active = !fin;
    endfunction

    task automatic send(input int a, input int b, input bit ai, input bit bi,
                        input bit f, input bit l);
        int w;
        model(a, b, ai, bi, f, l);
        in_valid = 1'b1; a_digit = 4'(a); b_digit = 4'(b);
        a_inv = ai; b_inv = bi; in_first = f; in_last = l;
        w = 0;
        do begin @(negedge clk); w++; end while (!in_ready && w < 100);
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++; $error("FAIL accept_timeout obs=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int w;
        in_valid = 1'b0;
        w = 0;
        do begin @(posedge clk); #3; w++; end
        while (!(obsq.size() >= expq.size() && !out_valid) && w < 500);
        #(-2+2);
    endtask

    task automatic compare(input string tag);
        int n;
        checks++;
        assert (obsq.size() === expq.size()) else begin
            errors++; $error("FAIL %s count obs=%0d exp=%0d", tag, obsq.size(), expq.size());
        end
        n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (obsq[i] === expq[i]) else begin
                errors++; $error("FAIL %s beat%0d obs=%h exp=%h", tag, i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete(); obs_t.delete();
    endtask

    task automatic run_t1();
        send(7, 8, 0, 0, 1, 0);
        send(5, 6, 0, 0, 0, 0);
        send(4, 3, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int a, b;
        bit ai, bi, f, l;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (cur() === 8'h00) else begin errors++; $error("FAIL reset_out obs=%h exp=00", cur()); end
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL reset_ovalid obs=%b exp=0", out_valid); end
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL reset_iready obs=%b exp=1", in_ready); end
        @(posedge clk); #1; reset = 1'b0;

        // T1: 457 + 368
        run_t1(); drain(); compare("t1");

        // T2: 9999 + 0001, full throughput
        send(9, 1, 0, 0, 1, 0);
        send(9, 0, 0, 0, 0, 0);
        send(9, 0, 0, 0, 0, 0);
        send(9, 0, 0, 0, 0, 1);
        drain();
        checks++;
        assert (obs_t.size() == 4 && (obs_t[3] - obs_t[0]) == 3) else begin
            errors++; $error("FAIL t2_throughput obs=%0d beats exp=4 consecutive", obs_t.size());
        end
        compare("t2");

        // T3: invalid digit on beat 2
        send(7, 8, 0, 0, 1, 0);
        send(12, 6, 1, 0, 0, 0);
        send(4, 3, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 1);
        drain(); compare("t3");

        // T4: downstream stall mid-operation
        send(7, 8, 0, 0, 1, 0);
        rdy_man = 1'b0;
        in_valid = 1'b1; a_digit = 4'd5; b_digit = 4'd6; in_first = 1'b0; in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            assert (in_ready === 1'b0) else begin errors++; $error("FAIL t4_stall obs=%b exp=0", in_ready); end
        end
        @(posedge clk); #1; rdy_man = 1'b1;
        send(5, 6, 0, 0, 0, 0);
        send(4, 3, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 1);
        drain(); compare("t4");

        // T5: NDIG overflow, fifth beat dropped
        send(1, 2, 0, 0, 1, 0);
        repeat (4) send(1, 2, 0, 0, 0, 0);
        drain(); compare("t5");

        // T6: reset mid-operation then a clean T1
        send(7, 8, 0, 0, 1, 0);
        send(5, 6, 0, 0, 0, 0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        assert (cur() === 8'h00 && out_valid === 1'b0) else begin
            errors++; $error("FAIL t6_reset obs=%h/%b exp=00/0", cur(), out_valid);
        end
        @(posedge clk); #1; reset = 1'b0;
        obsq.delete(); expq.delete(); obs_t.delete(); m_active = 1'b0;
        run_t1(); drain(); compare("t6");

        // Random beats with random back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            a = ($urandom_range(0, 9) != 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            b = ($urandom_range(0, 9) != 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            ai = (a > 9) | ($urandom_range(0, 30) == 0);
            bi = (b > 9) | ($urandom_range(0, 30) == 0);
            f = m_active ? ($urandom_range(0, 12) == 0) : ($urandom_range(0, 5) != 0);
            l = ($urandom_range(0, 3) == 0);
            send(a, b, ai, bi, f, l);
        end
        rdy_rand = 1'b0; rdy_man = 1'b1;
        drain(); compare("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
